// File: rtl/sram_burst_ctrl_pkg.sv
// ============================================================================
//  Module      : rl_mem_pkg
//  Description : Shared types and constants for the SRAM burst controller.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package rl_mem_pkg;

    localparam int unsigned BANK_ADDR_BITS  = 7;
    localparam int unsigned BANK_DATA_WIDTH = 16;
    localparam int unsigned RD_FIFO_DEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } burst_state_t;

    typedef struct packed {
        logic                      write;
        logic [BANK_ADDR_BITS-1:0] addr;
        logic [BANK_ADDR_BITS-1:0] len;
    } burst_cmd_t;

    // Words already buffered or still in the bank pipeline, after this cycle's pop,
    // must leave space for one more issue.
    function automatic logic rd_has_room(
        input logic [1:0] cnt,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] w_occ;
        w_occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
        return (w_occ < 3'(RD_FIFO_DEPTH));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_burst_ctrl_rd_skid.sv
// ============================================================================
//  Module      : sram_rd_skid
//  Description : Two-entry read-return FIFO carrying {last, data}.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sram_rd_skid
    import rl_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH:0] r_mem_q [RD_FIFO_DEPTH];
    logic [DATA_WIDTH:0] w_mem_d [RD_FIFO_DEPTH];
    logic                r_wr_ptr_q;
    logic                w_wr_ptr_d;
    logic                r_rd_ptr_q;
    logic                w_rd_ptr_d;
    logic [1:0]          r_cnt_q;
    logic [1:0]          w_cnt_d;
    logic                w_do_push;
    logic                w_do_pop;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_do_pop   = pop && (r_cnt_q != 2'd0);
        // A push into a full FIFO is only legal when the head leaves this cycle.
        w_do_push  = push && ((r_cnt_q < 2'(RD_FIFO_DEPTH)) || w_do_pop);
        if (w_do_push) begin
            w_mem_d[r_wr_ptr_q] = {push_last, push_data};
            w_wr_ptr_d          = ~r_wr_ptr_q;
        end
        if (w_do_pop) begin
            w_rd_ptr_d = ~r_rd_ptr_q;
        end
        w_cnt_d = r_cnt_q + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= 1'b0;
            r_rd_ptr_q <= 1'b0;
            r_cnt_q    <= 2'd0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    assign out_valid = (r_cnt_q != 2'd0);
    assign out_data  = r_mem_q[r_rd_ptr_q][DATA_WIDTH-1:0];
    assign out_last  = r_mem_q[r_rd_ptr_q][DATA_WIDTH];
    assign cnt       = r_cnt_q;

endmodule

`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
// ============================================================================
//  Module      : sram_burst_ctrl
//  Description : Burst initiator for one single-port SRAM bank with streamed
//                write data in and backpressured read data out.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sram_burst_ctrl
    import rl_mem_pkg::*;
#(
    parameter int DATA_WIDTH = BANK_DATA_WIDTH,
    parameter int ADDR_BITS  = BANK_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [ADDR_BITS-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_BITS-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    output logic                  sram_mem_en,
    output logic                  sram_mem_write_en,
    output logic                  sram_rst_b,
    input  logic [DATA_WIDTH-1:0] sram_data_out
);

    burst_state_t         r_state_q;
    burst_state_t         w_state_d;
    logic [ADDR_BITS-1:0] r_cur_addr_q;
    logic [ADDR_BITS-1:0] w_cur_addr_d;
    logic [ADDR_BITS-1:0] r_beats_left_q;
    logic [ADDR_BITS-1:0] w_beats_left_d;
    logic                 r_issue_active_q;
    logic                 w_issue_active_d;
    logic                 r_inflight_q;
    logic                 w_inflight_d;
    logic                 r_inflight_last_q;
    logic                 w_inflight_last_d;
    logic                 r_done_q;
    logic                 w_done_d;

    burst_cmd_t           w_cmd;
    logic                 w_cmd_fire;
    logic                 w_rd_fire;
    logic                 w_mem_en;
    logic                 w_mem_we;

    logic                 w_fifo_valid;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                 w_fifo_last;
    logic [1:0]           w_fifo_cnt;

    // The command struct is sized to the bank address width.
    assign w_cmd.write = cmd_write;
    assign w_cmd.addr  = BANK_ADDR_BITS'(cmd_addr);
    assign w_cmd.len   = BANK_ADDR_BITS'(cmd_len);

    assign cmd_ready  = (r_state_q == IDLE);
    assign wr_ready   = (r_state_q == WRITE);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_rd_fire  = w_fifo_valid && rd_ready;

    always_comb begin
        w_state_d         = r_state_q;
        w_cur_addr_d      = r_cur_addr_q;
        w_beats_left_d    = r_beats_left_q;
        w_issue_active_d  = r_issue_active_q;
        w_inflight_d      = 1'b0;
        w_inflight_last_d = 1'b0;
        w_done_d          = 1'b0;
        w_mem_en          = 1'b0;
        w_mem_we          = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (w_cmd_fire) begin
                    w_state_d        = w_cmd.write ? WRITE : READ;
                    w_cur_addr_d     = ADDR_BITS'(w_cmd.addr);
                    w_beats_left_d   = ADDR_BITS'(w_cmd.len);
                    w_issue_active_d = !w_cmd.write;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    w_mem_en     = 1'b1;
                    w_mem_we     = 1'b1;
                    w_cur_addr_d = r_cur_addr_q + ADDR_BITS'(1);
                    if (r_beats_left_q == '0) begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_beats_left_d = r_beats_left_q - ADDR_BITS'(1);
                    end
                end
            end
            READ: begin
                if (r_issue_active_q && rd_has_room(w_fifo_cnt, r_inflight_q, w_rd_fire)) begin
                    w_mem_en     = 1'b1;
                    w_inflight_d = 1'b1;
                    w_cur_addr_d = r_cur_addr_q + ADDR_BITS'(1);
                    if (r_beats_left_q == '0) begin
                        w_issue_active_d  = 1'b0;
                        w_inflight_last_d = 1'b1;
                    end else begin
                        w_beats_left_d = r_beats_left_q - ADDR_BITS'(1);
                    end
                end
                if (w_rd_fire && w_fifo_last) begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q         <= IDLE;
            r_cur_addr_q      <= '0;
            r_beats_left_q    <= '0;
            r_issue_active_q  <= 1'b0;
            r_inflight_q      <= 1'b0;
            r_inflight_last_q <= 1'b0;
            r_done_q          <= 1'b0;
        end else begin
            r_state_q         <= w_state_d;
            r_cur_addr_q      <= w_cur_addr_d;
            r_beats_left_q    <= w_beats_left_d;
            r_issue_active_q  <= w_issue_active_d;
            r_inflight_q      <= w_inflight_d;
            r_inflight_last_q <= w_inflight_last_d;
            r_done_q          <= w_done_d;
        end
    end

    // Bank data_out is valid the cycle after a read issue; capture it then.
    sram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight_q),
        .push_data (sram_data_out),
        .push_last (r_inflight_last_q),
        .pop       (w_rd_fire),
        .out_valid (w_fifo_valid),
        .out_data  (w_fifo_data),
        .out_last  (w_fifo_last),
        .cnt       (w_fifo_cnt)
    );

    assign rd_valid          = w_fifo_valid;
    assign rd_data           = w_fifo_data;
    assign rd_last           = w_fifo_valid && w_fifo_last;
    assign busy              = (r_state_q != IDLE);
    assign done              = r_done_q;
    assign sram_addr         = r_cur_addr_q;
    assign sram_data_in      = wr_data;
    assign sram_mem_en       = w_mem_en && !rst;
    assign sram_mem_write_en = w_mem_we && !rst;
    assign sram_rst_b        = !rst;

endmodule

`default_nettype wire
